// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, 4 data bits LSB first, parity, stop.
// Optional macro PARITY_SELF_CHECK_EN drops frames whose parity input is wrong.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_data, in_eparity,
//   in_oparity, in_valid  nibble and parity bits offered for transfer
//   in_ready              high while idle; transfer on in_valid && in_ready
//   tx                    registered serial line, idle high
//   busy                  a frame is on the line
//   done                  one-cycle pulse as the stop bit completes
//   par_err               one-cycle pulse when a frame is rejected (macro only)
module parity_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_eparity,
  input  logic       in_oparity,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       par_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  bitn, bitn_n;
  logic [3:0]  shreg, shreg_n;
  logic        par, par_n;
  logic        tx_q, tx_n;
  logic        done_q, done_n;
  logic        sel_par;
  logic        mismatch;
  logic        take;
  logic        last;

  assign sel_par  = ODD_PARITY ? in_oparity : in_eparity;
  assign in_ready = (state == IDLE);
  assign take     = in_valid && in_ready;
  assign last     = (cnt == LAST);
  assign tx       = tx_q;
  assign busy     = (state != IDLE);
  assign done     = done_q;

`ifdef PARITY_SELF_CHECK_EN
  logic exp_par;
  logic err_q;

  assign exp_par  = ODD_PARITY ? ~^in_data : ^in_data;
  assign mismatch = (exp_par != sel_par);
  assign par_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= take && mismatch;
    end
  end
`else
  assign mismatch = 1'b0;
  assign par_err  = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitn_n  = bitn;
    shreg_n = shreg;
    par_n   = par;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (take && !mismatch) begin
          state_n = START;
          cnt_n   = '0;
          shreg_n = in_data;
          par_n   = sel_par;
        end
      end
      START: begin
        if (last) begin
          state_n = DATA;
          cnt_n   = '0;
          bitn_n  = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (last) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (bitn == 2'd3) begin
            state_n = PARITY;
          end else begin
            bitn_n = bitn + 2'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      PARITY: begin
        if (last) begin
          state_n = STOP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (last) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level follows the state being entered so tx stays registered.
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitn   <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitn   <= bitn_n;
      shreg  <= shreg_n;
      par    <= par_n;
      tx_q   <= tx_n;
      done_q <= done_n;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx: even and odd instances share stimulus.
// Frames are predicted from data/parity rules and checked bit by bit on tx.
module tb_parity_frame_tx;

  localparam int C  = 4;
  localparam int FL = 7 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic       in_eparity = 1'b0;
  logic       in_oparity = 1'b0;
  logic       in_valid = 1'b0;
  logic       rdy0, tx0, busy0, done0, perr0;
  logic       rdy1, tx1, busy1, done1, perr1;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(C), .ODD_PARITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_eparity(in_eparity), .in_oparity(in_oparity),
    .in_valid(in_valid), .in_ready(rdy0), .tx(tx0),
    .busy(busy0), .done(done0), .par_err(perr0)
  );

  parity_frame_tx #(.CLKS_PER_BIT(C), .ODD_PARITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_eparity(in_eparity), .in_oparity(in_oparity),
    .in_valid(in_valid), .in_ready(rdy1), .tx(tx1),
    .busy(busy1), .done(done1), .par_err(perr1)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [6:0] q0[$];
  logic [6:0] q1[$];
  logic [6:0] cur[2];
  int exp_err[2] = '{0, 0};
  int got_err[2] = '{0, 0};
  int n_busy[2] = '{0, 0};
  int n_done[2] = '{0, 0};
  int start_cyc[2] = '{0, 0};
  int done_cyc[2] = '{0, 0};
  int k[2] = '{0, 0};
  bit inf[2] = '{0, 0};
  bit rogue[2] = '{0, 0};

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Parity bit that makes the total count of ones even (odd=0) or odd.
  function automatic logic par_of(input logic [3:0] d, input int odd);
    return (($countones(d) % 2) != odd);
  endfunction

  task automatic push(input logic [3:0] d, input logic ep, input logic op);
    for (int i = 0; i < 2; i++) begin
      logic s;
      bit bad;
      logic [6:0] fr;
      s = (i == 1) ? op : ep;
      bad = 1'b0;
`ifdef PARITY_SELF_CHECK_EN
      bad = (s != par_of(d, i));
`endif
      if (bad) begin
        exp_err[i]++;
      end else begin
        fr = {1'b1, s, d, 1'b0};
        if (i == 0) q0.push_back(fr);
        else q1.push_back(fr);
      end
    end
  endtask

  task automatic send(input logic [3:0] d, input logic ep, input logic op);
    int n;
    n = 0;
    while (!(rdy0 && rdy1) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(rdy0 && rdy1)) begin
      chk(1'b0, "ready_timeout", n, 400);
    end else begin
      in_data = d;
      in_eparity = ep;
      in_oparity = op;
      in_valid = 1'b1;
      @(posedge clk);
      push(d, ep, op);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk(!(busy0 || busy1), "idle_timeout", n, 400);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      logic t, b, dn, pe, e;
      logic [6:0] fr;
      t  = (i == 1) ? tx1 : tx0;
      b  = (i == 1) ? busy1 : busy0;
      dn = (i == 1) ? done1 : done0;
      pe = (i == 1) ? perr1 : perr0;
      if (pe) got_err[i]++;
      if (b) n_busy[i]++;
      if (dn) begin
        n_done[i]++;
        done_cyc[i] = cyc;
      end
      if (!b) rogue[i] = 1'b0;
      if (rst) begin
        inf[i] = 1'b0;
      end else begin
        if (!inf[i] && b && !rogue[i]) begin
          start_cyc[i] = cyc;
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            chk(1'b0, $sformatf("unexpected_frame%0d", i), 1, 0);
            rogue[i] = 1'b1;
          end else begin
            fr = (i == 0) ? q0.pop_front() : q1.pop_front();
            cur[i] = fr;
            inf[i] = 1'b1;
            k[i] = 0;
          end
        end
        if (inf[i]) begin
          if (k[i] < FL) begin
            fr = cur[i];
            e = fr[k[i] / C];
            chk(t == e && b && !dn,
                $sformatf("frame%0d_bit%0d_cyc%0d", i, k[i] / C, k[i]),
                {dn, b, t}, {1'b0, 1'b1, e});
            k[i]++;
          end else begin
            chk(dn && !b && t, $sformatf("done%0d", i),
                {dn, b, t}, 3'b101);
            inf[i] = 1'b0;
          end
        end else if (!rogue[i]) begin
          chk(t && !dn, $sformatf("idle_line%0d", i), {dn, t}, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0[2], d0[2], d1;
    logic [3:0] d;
    logic ep, op;

    repeat (2) @(posedge clk);
    #1;
    chk({tx0, busy0, done0, rdy0, perr0} == 5'b10010, "reset0",
        {tx0, busy0, done0, rdy0, perr0}, 5'b10010);
    chk({tx1, busy1, done1, rdy1, perr1} == 5'b10010, "reset1",
        {tx1, busy1, done1, rdy1, perr1}, 5'b10010);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(4'b1011, 1'b1, 1'b0);
    wait_idle();
    send(4'b0000, 1'b0, 1'b1);
    wait_idle();

    for (int i = 0; i < 2; i++) begin
      b0[i] = n_busy[i];
      d0[i] = n_done[i];
    end
    send(4'b0101, 1'b0, 1'b1);
    send(4'b1110, 1'b1, 1'b0);
    d1 = done_cyc[0];
    wait_idle();
    chk(start_cyc[0] == d1 + 1, "b2b_gap", start_cyc[0] - d1, 1);
    for (int i = 0; i < 2; i++) begin
      chk(n_busy[i] - b0[i] == 2 * FL, $sformatf("b2b_busy%0d", i),
          n_busy[i] - b0[i], 2 * FL);
      chk(n_done[i] - d0[i] == 2, $sformatf("b2b_done%0d", i),
          n_done[i] - d0[i], 2);
    end

    send(4'b0110, 1'b0, 1'b1);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk({tx0, rdy0, busy0, done0} == 4'b1100, "midrst0",
        {tx0, rdy0, busy0, done0}, 4'b1100);
    chk({tx1, rdy1, busy1, done1} == 4'b1100, "midrst1",
        {tx1, rdy1, busy1, done1}, 4'b1100);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(4'b1111, 1'b0, 1'b1);
    wait_idle();

    send(4'b0001, 1'b0, 1'b0);
    wait_idle();

    for (int n = 0; n < 20; n++) begin
      d  = 4'($urandom_range(0, 15));
      ep = par_of(d, 0);
      op = par_of(d, 1);
      if ($urandom_range(0, 3) == 0) ep = ~ep;
      if ($urandom_range(0, 3) == 0) op = ~op;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(d, ep, op);
    end
    wait_idle();

    chk(q0.size() == 0, "pending0", q0.size(), 0);
    chk(q1.size() == 0, "pending1", q1.size(), 0);
    chk(got_err[0] == exp_err[0], "par_err0", got_err[0], exp_err[0]);
    chk(got_err[1] == exp_err[1], "par_err1", got_err[1], exp_err[1]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
